sr_trace_buffer: RTL and testbench
==================================

Name: sr_trace_buffer

Overview:
- Synthesisable instruction-trace capture unit for sr_cpu. It is the on-chip successor of the simulation-only cycle/pc/instr/a0 printout and timeout stop.
- Records retired instructions into a parametrised ring buffer: cycle stamp, pc, instr and register writeback.
- Stops capture on a PC breakpoint (with post-trigger depth), on cycle timeout, or on buffer full.
- Asserts halt to gate the CPU clock enable, then drains entries oldest-first over a valid/ready port.

Parameters:
- DEPTH, 16, trace entries; power of two, minimum 2.
- AW, 4, log2(DEPTH).
- CYC_W, 16, cycle-stamp and timeout counter width.
- TIMEOUT, 120, capture-cycle limit; 0 disables the timeout.
- POST_TRIG, 4, retirements captured after the breakpoint entry.
- WRAP, 1, 1 = circular (overwrite oldest); 0 = stop when full.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- arm  in  1  start/restart capture (pulse)
- ret_valid  in  1  instruction retires this cycle
- ret_pc  in  32  pc of retiring instruction
- ret_instr  in  32  instruction word
- ret_we  in  1  register-file write enable
- ret_rd  in  5  destination register
- ret_wd  in  32  writeback data
- bp_en  in  1  breakpoint enable
- bp_pc  in  32  breakpoint address
- halt  out  1  CPU stop request
- state  out  2  0 IDLE, 1 CAPTURE, 2 POST, 3 DUMP
- trig_hit  out  1  breakpoint fired
- tmo_hit  out  1  timeout fired
- count  out  AW+1  valid entries held
- rd_valid  out  1  entry available
- rd_ready  in  1  consumer accepts entry
- rd_cycle  out  CYC_W  cycle stamp
- rd_pc  out  32  traced pc
- rd_instr  out  32  traced instruction
- rd_we  out  1  traced write enable
- rd_rd  out  5  traced rd
- rd_wd  out  32  traced write data

Behaviour:
- Reset: state IDLE; wr_ptr, count, cycle counter and post counter cleared; halt, trig_hit, tmo_hit, rd_valid all 0. rd_* data outputs are 0 while rd_valid=0. Memory contents are not reset.
- arm is accepted in IDLE or DUMP.
  - Effect: next state CAPTURE; clears count, wr_ptr, cycle, trig_hit, tmo_hit; deasserts halt.
  - Any undrained entries are discarded.
  - arm in CAPTURE/POST is ignored.
- Cycle counter:
  - Increments every clk in CAPTURE and POST.
  - Its pre-increment value is the stamp of an entry written that cycle.
  - Saturates at all-ones.
- Write (CAPTURE/POST, ret_valid=1): entry stored at wr_ptr; wr_ptr+1 mod DEPTH.
  - count increments up to DEPTH.
  - At DEPTH with WRAP=1, count holds and the oldest entry is overwritten.
- CAPTURE exits:
  - Breakpoint: ret_valid && bp_en && ret_pc==bp_pc. The entry is written and trig_hit set. Next state is POST with post counter = POST_TRIG, or DUMP if POST_TRIG=0.
  - Timeout: TIMEOUT!=0 and cycle==TIMEOUT-1. Any entry that cycle is written, tmo_hit set, next state DUMP.
  - Full: WRAP=0 and the write makes count==DEPTH. Next state DUMP.
- POST:
  - Each write decrements the post counter; the write that brings it to 0 moves to DUMP.
  - Timeout and full (WRAP=0) still apply.
  - Breakpoint matches in POST are ignored.
- Simultaneous events, same cycle: timeout > full > breakpoint for the next state.
  - The entry is still written.
  - trig_hit is set even if the breakpoint loses.
- DUMP:
  - halt=1 from the first DUMP cycle.
  - Writes are ignored even if ret_valid=1.
  - rd_ptr = (wr_ptr - count) mod DEPTH, i.e. oldest first.
  - rd_valid = (count!=0). rd_* are combinational reads of mem[rd_ptr] (first-word fall-through).
  - rd_valid && rd_ready: count decrements; the next entry appears the next cycle.
  - When count reaches 0, rd_valid=0 and the state stays DUMP until arm.
  - rd_valid is never 1 outside DUMP.
- Latency: the entry written on the cycle that causes DUMP is readable, if oldest, on the first DUMP cycle.
- rst mid-capture or mid-drain: immediate return to reset values; buffered data is lost.

Test Plan:
- TIMEOUT=120, WRAP=1, ret_valid every cycle with pc 0,4,8…, arm at cycle 0:
  - Response: tmo_hit at capture cycle 119, halt=1, count=16.
  - Drain yields rd_cycle 104..119 and rd_pc 0x1A0..0x1DC in order.
- bp_pc=0x20, bp_en=1, POST_TRIG=4, ret_valid every cycle:
  - Response: trig_hit; DUMP after pc 0x30 is written; count=13.
  - Last drained rd_pc=0x30; tmo_hit=0.
- WRAP=0, DEPTH=16, ret_valid every other cycle:
  - Response: DUMP on the 16th write, count=16.
  - First drained rd_cycle=0, last rd_cycle=30.
- Breakpoint hit on the same cycle as timeout:
  - Response: tmo_hit=1, trig_hit=1, next state DUMP (POST skipped), matching entry present.
- Drain with rd_ready toggled 1,0,1,0:
  - Response: each entry is held stable while rd_ready=0; no loss or duplication; rd_valid falls after the last.
- Assert arm mid-drain (5 entries left), then rst during CAPTURE:
  - After arm: count=0, state CAPTURE, halt=0, flags cleared.
  - After rst: state IDLE, all outputs 0.

Source files
------------

// File: rtl/sr_trace_buffer.sv
// Instruction-trace capture unit for sr_cpu.
// Retirements go into a ring buffer of {cycle, pc, instr, we, rd, wd}. Capture stops on a
// breakpoint (after POST_TRIG further retirements), on a cycle timeout, or when the buffer
// fills (WRAP=0). The CPU is then halted and the entries are drained oldest-first.
module sr_trace_buffer #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AW        = 4,
  parameter int unsigned CYC_W     = 16,
  parameter int unsigned TIMEOUT   = 120,
  parameter int unsigned POST_TRIG = 4,
  parameter bit          WRAP      = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             ret_valid,
  input  logic [31:0]      ret_pc,
  input  logic [31:0]      ret_instr,
  input  logic             ret_we,
  input  logic [4:0]       ret_rd,
  input  logic [31:0]      ret_wd,
  input  logic             bp_en,
  input  logic [31:0]      bp_pc,
  output logic             halt,
  output logic [1:0]       state,
  output logic             trig_hit,
  output logic             tmo_hit,
  output logic [AW:0]      count,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [CYC_W-1:0] rd_cycle,
  output logic [31:0]      rd_pc,
  output logic [31:0]      rd_instr,
  output logic             rd_we,
  output logic [4:0]       rd_rd,
  output logic [31:0]      rd_wd
);

  // Post counter must hold POST_TRIG and stay at least one bit wide when POST_TRIG=0.
  localparam int unsigned PW = $clog2(POST_TRIG + 2);
  localparam int unsigned EW = CYC_W + 32 + 32 + 1 + 5 + 32;

  // Packed entry layout, LSB first: wd, rd, we, instr, pc, cycle.
  localparam int unsigned RdLsb    = 32;
  localparam int unsigned WeBit    = 37;
  localparam int unsigned InstrLsb = 38;
  localparam int unsigned PcLsb    = 70;
  localparam int unsigned CycLsb   = 102;

  localparam logic [AW:0]      CountFull = (AW + 1)'(DEPTH);
  localparam logic [AW:0]      CountLast = (AW + 1)'(DEPTH - 1);
  localparam logic [CYC_W-1:0] TmoLast   = CYC_W'(TIMEOUT - 1);
  localparam logic [PW-1:0]    PostInit  = PW'(POST_TRIG);
  localparam bit               TmoEn     = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCapture = 2'd1,
    StPost    = 2'd2,
    StDump    = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [PW-1:0]    post_q, post_d;
  logic             trig_q, trig_d;
  logic             tmo_q, tmo_d;

  logic [EW-1:0]    mem_q [DEPTH];

  logic             capturing;
  logic             wr_en;
  logic             bp_match;
  logic             tmo_ev;
  logic             full_ev;
  logic             post_done;
  logic             arm_go;
  logic             rd_fire;
  logic             rd_avail;
  logic [AW-1:0]    rd_ptr;
  logic [EW-1:0]    wr_entry;
  logic [EW-1:0]    rd_entry;

  // Capture-side events decoded from the current state and retirement port.
  always_comb begin
    capturing = (state_q == StCapture) || (state_q == StPost);
    wr_en     = capturing && ret_valid;
    bp_match  = (state_q == StCapture) && ret_valid && bp_en && (ret_pc == bp_pc);
    tmo_ev    = capturing && TmoEn && (cyc_q == TmoLast);
    full_ev   = wr_en && !WRAP && (count_q == CountLast);
    post_done = (state_q == StPost) && wr_en && (post_q == PW'(1));
    arm_go    = arm && ((state_q == StIdle) || (state_q == StDump));
    rd_avail  = (state_q == StDump) && (count_q != '0);
    rd_fire   = rd_avail && rd_ready;
    wr_entry  = {cyc_q, ret_pc, ret_instr, ret_we, ret_rd, ret_wd};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; timeout beats full beats breakpoint when they coincide.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDump: begin
        if (arm) state_d = StCapture;
      end
      StCapture: begin
        if (tmo_ev || full_ev) begin
          state_d = StDump;
        end else if (bp_match) begin
          state_d = (POST_TRIG == 0) ? StDump : StPost;
        end
      end
      StPost: begin
        if (tmo_ev || full_ev || post_done) state_d = StDump;
      end
      default: state_d = StIdle;
    endcase
  end

  // Pointer, occupancy, cycle stamp, post counter and sticky flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    cyc_d    = cyc_q;
    post_d   = post_q;
    trig_d   = trig_q;
    tmo_d    = tmo_q;
    if (arm_go) begin
      wr_ptr_d = '0;
      count_d  = '0;
      cyc_d    = '0;
      trig_d   = 1'b0;
      tmo_d    = 1'b0;
    end else begin
      if (capturing && (cyc_q != '1)) cyc_d = cyc_q + 1'b1;
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        // Full ring with WRAP=1: count holds, oldest entry is overwritten.
        if (count_q != CountFull) count_d = count_q + 1'b1;
      end
      if (rd_fire) count_d = count_q - 1'b1;
      if (bp_match) trig_d = 1'b1;
      if (tmo_ev) tmo_d = 1'b1;
      if (bp_match) begin
        post_d = PostInit;
      end else if ((state_q == StPost) && wr_en) begin
        post_d = post_q - 1'b1;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
      cyc_q    <= '0;
      post_q   <= '0;
      trig_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      cyc_q    <= cyc_d;
      post_q   <= post_d;
      trig_q   <= trig_d;
      tmo_q    <= tmo_d;
    end
  end

  // Trace storage; contents survive reset and are simply ignored until rewritten.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_entry;
  end

  // Outputs: halt follows DUMP, read side is first-word fall-through from the oldest entry.
  always_comb begin
    halt     = (state_q == StDump);
    state    = state_q;
    trig_hit = trig_q;
    tmo_hit  = tmo_q;
    count    = count_q;
    rd_valid = rd_avail;
    // count=DEPTH has zero low bits, so the oldest entry is at wr_ptr itself.
    rd_ptr   = wr_ptr_q - count_q[AW-1:0];
    rd_entry = rd_avail ? mem_q[rd_ptr] : '0;
    rd_cycle = rd_entry[CycLsb +: CYC_W];
    rd_pc    = rd_entry[PcLsb +: 32];
    rd_instr = rd_entry[InstrLsb +: 32];
    rd_we    = rd_entry[WeBit];
    rd_rd    = rd_entry[RdLsb +: 5];
    rd_wd    = rd_entry[31:0];
  end

endmodule

// File: tb/tb_sr_trace_buffer.sv
// Bench for sr_trace_buffer: a circular/timeout instance and a stop-when-full instance.
module tb_sr_trace_buffer;

  typedef struct packed {
    logic [15:0] cyc;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
  } ent_t;

  logic        clk, rst, arm, arm_w;
  logic        ret_valid, ret_we, bp_en, rd_ready;
  logic [31:0] ret_pc, ret_instr, ret_wd, bp_pc;
  logic [4:0]  ret_rd;

  logic        halt, trig_hit, tmo_hit, rd_valid, rd_we;
  logic [1:0]  state;
  logic [4:0]  count, rd_rd;
  logic [15:0] rd_cycle;
  logic [31:0] rd_pc, rd_instr, rd_wd;

  logic        w_halt, w_trig_hit, w_tmo_hit, w_rd_valid, w_rd_we;
  logic [1:0]  w_state;
  logic [4:0]  w_count, w_rd_rd;
  logic [15:0] w_rd_cycle;
  logic [31:0] w_rd_pc, w_rd_instr, w_rd_wd;

  int   n_checks = 0;
  int   n_fail   = 0;
  ent_t exp_q[$];

  sr_trace_buffer #(
    .DEPTH(16), .AW(4), .CYC_W(16), .TIMEOUT(120), .POST_TRIG(4), .WRAP(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .arm(arm), .ret_valid(ret_valid), .ret_pc(ret_pc),
    .ret_instr(ret_instr), .ret_we(ret_we), .ret_rd(ret_rd), .ret_wd(ret_wd),
    .bp_en(bp_en), .bp_pc(bp_pc), .halt(halt), .state(state), .trig_hit(trig_hit),
    .tmo_hit(tmo_hit), .count(count), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_cycle(rd_cycle), .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_we(rd_we),
    .rd_rd(rd_rd), .rd_wd(rd_wd)
  );

  sr_trace_buffer #(
    .DEPTH(16), .AW(4), .CYC_W(16), .TIMEOUT(0), .POST_TRIG(4), .WRAP(1'b0)
  ) dut_w (
    .clk(clk), .rst(rst), .arm(arm_w), .ret_valid(ret_valid), .ret_pc(ret_pc),
    .ret_instr(ret_instr), .ret_we(ret_we), .ret_rd(ret_rd), .ret_wd(ret_wd),
    .bp_en(bp_en), .bp_pc(bp_pc), .halt(w_halt), .state(w_state), .trig_hit(w_trig_hit),
    .tmo_hit(w_tmo_hit), .count(w_count), .rd_valid(w_rd_valid), .rd_ready(rd_ready),
    .rd_cycle(w_rd_cycle), .rd_pc(w_rd_pc), .rd_instr(w_rd_instr), .rd_we(w_rd_we),
    .rd_rd(w_rd_rd), .rd_wd(w_rd_wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one retirement slot for capture cycle c; optionally record it in the scoreboard.
  task automatic drive_ret(input bit v, input int c, input bit push, input bit trim);
    ent_t e;
    ret_valid = v;
    ret_pc    = 32'(c * 4);
    ret_instr = {16'hC0DE, 16'(c)};
    ret_we    = c[0];
    ret_rd    = 5'(c);
    ret_wd    = ret_pc ^ 32'hFFFF_0000;
    if (v && push) begin
      e.cyc = 16'(c); e.pc = ret_pc; e.instr = ret_instr;
      e.we = ret_we; e.rd = ret_rd; e.wd = ret_wd;
      exp_q.push_back(e);
      if (trim && exp_q.size() > 16) void'(exp_q.pop_front());
    end
  endtask

  task automatic do_arm(input bit sel);
    ret_valid = 1'b0;
    if (sel) arm_w = 1'b1;
    else     arm   = 1'b1;
    tick();
    arm   = 1'b0;
    arm_w = 1'b0;
  endtask

  // Pop scoreboard entries as the selected instance hands them out.
  task automatic drain(input bit sel, input bit toggle, input logic [31:0] last_pc_exp,
                       input logic [15:0] last_cyc_exp);
    int   guard = 0;
    bit   stop  = 1'b0;
    ent_t got;
    logic v;
    logic [31:0] last_pc  = '0;
    logic [15:0] last_cyc = '0;
    while (exp_q.size() > 0 && guard < 400 && !stop) begin
      rd_ready  = toggle ? (guard % 2 == 0) : 1'b1;
      v         = sel ? w_rd_valid : rd_valid;
      got.cyc   = sel ? w_rd_cycle : rd_cycle;
      got.pc    = sel ? w_rd_pc    : rd_pc;
      got.instr = sel ? w_rd_instr : rd_instr;
      got.we    = sel ? w_rd_we    : rd_we;
      got.rd    = sel ? w_rd_rd    : rd_rd;
      got.wd    = sel ? w_rd_wd    : rd_wd;
      n_checks++;
      if (v !== 1'b1) begin
        n_fail++;
        $display("FAIL drain_valid: rd_valid=%b required 1 with %0d entries pending",
                 v, exp_q.size());
        stop = 1'b1;
      end else begin
        n_checks++;
        if (got !== exp_q[0]) begin
          n_fail++;
          $display("FAIL drain_entry: got %h required %h", got, exp_q[0]);
        end
        if (rd_ready) begin
          last_pc  = got.pc;
          last_cyc = got.cyc;
          void'(exp_q.pop_front());
        end
      end
      tick();
      guard++;
    end
    rd_ready = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_done: %0d entries left, required 0", exp_q.size());
    end
    n_checks++;
    if (last_pc !== last_pc_exp || last_cyc !== last_cyc_exp) begin
      n_fail++;
      $display("FAIL drain_last: pc=%h cyc=%0d required pc=%h cyc=%0d",
               last_pc, last_cyc, last_pc_exp, last_cyc_exp);
    end
    v = sel ? w_rd_valid : rd_valid;
    n_checks++;
    if (v !== 1'b0 || (sel ? w_count : count) !== 5'd0 || (sel ? w_state : state) !== 2'd3) begin
      n_fail++;
      $display("FAIL drain_empty: rd_valid=%b count=%0d state=%0d required 0/0/3",
               v, sel ? w_count : count, sel ? w_state : state);
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_checks++;
    if ({state, halt, trig_hit, tmo_hit, count, rd_valid} !== 11'd0 || rd_pc !== 32'd0) begin
      n_fail++;
      $display("FAIL reset: state=%0d halt=%b trig=%b tmo=%b count=%0d rd_valid=%b rd_pc=%h required all 0",
               state, halt, trig_hit, tmo_hit, count, rd_valid, rd_pc);
    end
    n_checks++;
    if ({w_state, w_halt, w_count, w_rd_valid} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_w: state=%0d halt=%b count=%0d rd_valid=%b required all 0",
               w_state, w_halt, w_count, w_rd_valid);
    end
  endtask

  task automatic test_timeout();
    exp_q.delete();
    do_arm(1'b0);
    n_checks++;
    if (state !== 2'd1 || halt !== 1'b0 || count !== 5'd0) begin
      n_fail++;
      $display("FAIL tmo_arm: state=%0d halt=%b count=%0d required 1/0/0", state, halt, count);
    end
    for (int c = 0; c < 120; c++) begin
      drive_ret(1'b1, c, 1'b1, 1'b1);
      tick();
      if (c == 118) begin
        n_checks++;
        if (state !== 2'd1 || tmo_hit !== 1'b0 || rd_valid !== 1'b0 || rd_pc !== 32'd0) begin
          n_fail++;
          $display("FAIL tmo_before: state=%0d tmo=%b rd_valid=%b rd_pc=%h required 1/0/0/0",
                   state, tmo_hit, rd_valid, rd_pc);
        end
      end
    end
    // Retirements while dumping must not be recorded.
    drive_ret(1'b1, 1000, 1'b0, 1'b0);
    n_checks++;
    if (state !== 2'd3 || tmo_hit !== 1'b1 || halt !== 1'b1 || count !== 5'd16 ||
        trig_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_fire: state=%0d tmo=%b halt=%b count=%0d trig=%b required 3/1/1/16/0",
               state, tmo_hit, halt, count, trig_hit);
    end
    tick();
    tick();
    ret_valid = 1'b0;
    n_checks++;
    if (count !== 5'd16 || rd_cycle !== 16'd104 || rd_pc !== 32'h1A0) begin
      n_fail++;
      $display("FAIL tmo_oldest: count=%0d rd_cycle=%0d rd_pc=%h required 16/104/1a0",
               count, rd_cycle, rd_pc);
    end
    drain(1'b0, 1'b0, 32'h1DC, 16'd119);
  endtask

  task automatic test_breakpoint();
    exp_q.delete();
    bp_en = 1'b1;
    bp_pc = 32'h20;
    do_arm(1'b0);
    for (int c = 0; c <= 12; c++) begin
      drive_ret(1'b1, c, 1'b1, 1'b1);
      tick();
      if (c == 8) begin
        n_checks++;
        if (state !== 2'd2 || trig_hit !== 1'b1 || halt !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_post: state=%0d trig=%b halt=%b required 2/1/0", state, trig_hit, halt);
        end
      end
    end
    ret_valid = 1'b0;
    bp_en     = 1'b0;
    n_checks++;
    if (state !== 2'd3 || count !== 5'd13 || tmo_hit !== 1'b0 || halt !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_dump: state=%0d count=%0d tmo=%b halt=%b required 3/13/0/1",
               state, count, tmo_hit, halt);
    end
    drain(1'b0, 1'b0, 32'h30, 16'd12);
  endtask

  task automatic test_full_nowrap();
    exp_q.delete();
    do_arm(1'b1);
    for (int c = 0; c <= 30; c++) begin
      drive_ret(c % 2 == 0, c, 1'b1, 1'b0);
      tick();
      if (c == 28) begin
        n_checks++;
        if (w_state !== 2'd1 || w_count !== 5'd15) begin
          n_fail++;
          $display("FAIL full_before: state=%0d count=%0d required 1/15", w_state, w_count);
        end
      end
    end
    ret_valid = 1'b0;
    n_checks++;
    if (w_state !== 2'd3 || w_count !== 5'd16 || w_halt !== 1'b1 || w_tmo_hit !== 1'b0 ||
        w_rd_cycle !== 16'd0) begin
      n_fail++;
      $display("FAIL full_dump: state=%0d count=%0d halt=%b tmo=%b rd_cycle=%0d required 3/16/1/0/0",
               w_state, w_count, w_halt, w_tmo_hit, w_rd_cycle);
    end
    drain(1'b1, 1'b0, 32'h78, 16'd30);
  endtask

  task automatic test_bp_timeout();
    exp_q.delete();
    bp_en = 1'b1;
    bp_pc = 32'h1DC;
    do_arm(1'b0);
    for (int c = 0; c < 120; c++) begin
      drive_ret(1'b1, c, 1'b1, 1'b1);
      tick();
    end
    ret_valid = 1'b0;
    bp_en     = 1'b0;
    n_checks++;
    if (state !== 2'd3 || tmo_hit !== 1'b1 || trig_hit !== 1'b1 || count !== 5'd16) begin
      n_fail++;
      $display("FAIL bp_tmo: state=%0d tmo=%b trig=%b count=%0d required 3/1/1/16",
               state, tmo_hit, trig_hit, count);
    end
  endtask

  task automatic test_backpressure();
    // Buffer left by test_bp_timeout; last entry must be the breakpoint match.
    drain(1'b0, 1'b1, 32'h1DC, 16'd119);
  endtask

  task automatic test_arm_mid_drain();
    exp_q.delete();
    bp_en = 1'b1;
    bp_pc = 32'h20;
    do_arm(1'b0);
    for (int c = 0; c <= 12; c++) begin
      drive_ret(1'b1, c, 1'b0, 1'b0);
      tick();
    end
    ret_valid = 1'b0;
    bp_en     = 1'b0;
    rd_ready  = 1'b1;
    repeat (8) tick();
    rd_ready = 1'b0;
    n_checks++;
    if (count !== 5'd5 || rd_valid !== 1'b1 || rd_pc !== 32'h20) begin
      n_fail++;
      $display("FAIL mid_left: count=%0d rd_valid=%b rd_pc=%h required 5/1/20", count, rd_valid, rd_pc);
    end
    do_arm(1'b0);
    n_checks++;
    if (state !== 2'd1 || count !== 5'd0 || halt !== 1'b0 || trig_hit !== 1'b0 ||
        tmo_hit !== 1'b0 || rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_arm: state=%0d count=%0d halt=%b trig=%b tmo=%b rd_valid=%b required 1/0/0/0/0/0",
               state, count, halt, trig_hit, tmo_hit, rd_valid);
    end
    for (int c = 0; c < 3; c++) begin
      drive_ret(1'b1, c, 1'b0, 1'b0);
      tick();
    end
    ret_valid = 1'b0;
    n_checks++;
    if (count !== 5'd3 || rd_pc !== 32'd0 || rd_wd !== 32'd0) begin
      n_fail++;
      $display("FAIL cap_count: count=%0d rd_pc=%h rd_wd=%h required 3/0/0", count, rd_pc, rd_wd);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({state, halt, trig_hit, tmo_hit, count, rd_valid} !== 11'd0 ||
        {rd_cycle, rd_pc, rd_instr, rd_we, rd_rd, rd_wd} !== '0) begin
      n_fail++;
      $display("FAIL rst_cap: state=%0d halt=%b trig=%b tmo=%b count=%0d rd_valid=%b rd_pc=%h required all 0",
               state, halt, trig_hit, tmo_hit, count, rd_valid, rd_pc);
    end
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; arm_w = 1'b0; rd_ready = 1'b0;
    ret_valid = 1'b0; ret_pc = '0; ret_instr = '0; ret_we = 1'b0; ret_rd = '0; ret_wd = '0;
    bp_en = 1'b0; bp_pc = '0;
    test_reset();
    test_timeout();
    test_breakpoint();
    test_full_nowrap();
    test_bp_timeout();
    test_backpressure();
    test_arm_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
